// File: rtl/pc_update_pkg.sv
// Shared phase and sequencing constants for the PC commit path.
// Also used by the branch-decision register so both counters agree.
package pc_update_pkg;

    localparam int PHASE_W      = 4;
    localparam int PHASE_COUNT  = 10;
    localparam int SAMPLE_PHASE = 7;
    localparam int UPDATE_PHASE = 9;
    localparam int DECIDE_PHASE = 5;
    localparam int INSTR_BYTES  = 4;
    localparam int COUNT_W      = 8;

    typedef enum logic [1:0] {
        C_HOLD,
        C_FAULT,
        C_TAKEN,
        C_SEQ
    } commit_t;

    function automatic logic [PHASE_W-1:0] next_phase(
        input logic [PHASE_W-1:0] p
    );
        if (p == PHASE_W'(PHASE_COUNT - 1))
            return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/pc_update_if.sv
// Bundle between the branch-decision register, pc_update and fetch.
// master drives the decision inputs; slave is the PC commit block.
interface pc_update_if
    import pc_update_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic               branch_taken;
    logic [DATA_W-1:0]  offset;
    logic               halt;
    logic [DATA_W-1:0]  pc;
    logic [PHASE_W-1:0] phase;
    logic               fetch_strobe;
    logic [COUNT_W-1:0] taken_count;
    logic               misaligned;

    modport master (
        output branch_taken,
        output offset,
        output halt,
        input  pc,
        input  phase,
        input  fetch_strobe,
        input  taken_count,
        input  misaligned
    );

    modport slave (
        input  branch_taken,
        input  offset,
        input  halt,
        output pc,
        output phase,
        output fetch_strobe,
        output taken_count,
        output misaligned
    );
endinterface

// File: rtl/pc_update_phase_counter.sv
// Free-running mod-PHASE_COUNT counter with sample/update strobes.
// Never stalls; only reset brings it back to phase 0.
module phase_counter
    import pc_update_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [PHASE_W-1:0] phase,
    output logic               sample_hit,
    output logic               update_hit
);

    logic [PHASE_W-1:0] phase_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            phase_q <= '0;
        else
            phase_q <= next_phase(phase_q);
    end

    assign phase      = phase_q;
    assign sample_hit = (phase_q == PHASE_W'(SAMPLE_PHASE));
    assign update_hit = (phase_q == PHASE_W'(UPDATE_PHASE));

endmodule

// File: rtl/pc_update.sv
// Samples the branch decision once per instruction and commits the
// next PC, with halt, sticky misalignment trap and fetch strobe.
module pc_update
    import pc_update_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
)(
    input  logic        clock,
    input  logic        reset,
    pc_update_if.slave  bus
);

    localparam logic [DATA_W-1:0] STEP  = DATA_W'(INSTR_BYTES);
    localparam logic [DATA_W-1:0] ALIGN = DATA_W'(INSTR_BYTES - 1);

    logic [PHASE_W-1:0] phase;
    logic               sample_hit;
    logic               update_hit;

    logic [DATA_W-1:0]  pc_q;
    logic [DATA_W-1:0]  target_q;
    logic               taken_q;
    logic               strobe_q;
    logic               mis_q;
    logic [COUNT_W-1:0] count_q;

    commit_t            commit;
    logic               target_bad;
    logic               advance;

    phase_counter u_phase (
        .clock      (clock),
        .reset      (reset),
        .phase      (phase),
        .sample_hit (sample_hit),
        .update_hit (update_hit)
    );

    assign target_bad = |(target_q & ALIGN);

    // Priority: halt, then the sticky trap, then the new fault check.
    always_comb begin
        commit = C_SEQ;
        if (bus.halt)
            commit = C_HOLD;
        else if (mis_q)
            commit = C_HOLD;
        else if (taken_q && target_bad)
            commit = C_FAULT;
        else if (taken_q)
            commit = C_TAKEN;
    end

    assign advance = update_hit &&
                     (commit == C_TAKEN || commit == C_SEQ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            target_q <= '0;
            taken_q  <= 1'b0;
            strobe_q <= 1'b0;
            mis_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            strobe_q <= advance;
            if (sample_hit) begin
                taken_q  <= bus.branch_taken;
                target_q <= pc_q + bus.offset;
            end
            if (update_hit) begin
                unique case (commit)
                    C_HOLD: ;
                    C_FAULT: mis_q <= 1'b1;
                    C_TAKEN: begin
                        pc_q    <= target_q;
                        count_q <= count_q + 1'b1;
                    end
                    C_SEQ: pc_q <= pc_q + STEP;
                    default: ;
                endcase
            end
        end
    end

    assign bus.pc           = pc_q;
    assign bus.phase        = phase;
    assign bus.fetch_strobe = strobe_q;
    assign bus.taken_count  = count_q;
    assign bus.misaligned   = mis_q;

endmodule

// File: tb/tb_pc_update.sv
// Scoreboard bench for pc_update: driver pushes expected state per
// edge from an instruction-level model; monitor pops and compares.
module tb_pc_update;
    import pc_update_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pc_update_if #(.DATA_W(32)) bus ();

    pc_update dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  phase;
        logic        fs;
        logic [7:0]  cnt;
        logic        mis;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        m_tq;
    logic        m_fs;
    logic        m_mis;
    logic [7:0]  m_cnt;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, req);
        end
    endtask

    always @(posedge clock) begin
        obs_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pc", bus.pc, e.pc);
            check("sb_phase", 32'(bus.phase), 32'(e.phase));
            check("sb_strobe", 32'(bus.fetch_strobe), 32'(e.fs));
            check("sb_count", 32'(bus.taken_count), 32'(e.cnt));
            check("sb_misaligned", 32'(bus.misaligned), 32'(e.mis));
        end
    end

    task automatic m_reset();
        m_phase = 0;
        m_pc    = '0;
        m_tgt   = '0;
        m_tq    = 1'b0;
        m_fs    = 1'b0;
        m_mis   = 1'b0;
        m_cnt   = '0;
    endtask

    // One clock: drive inputs, predict the state after the edge.
    task automatic step(logic bt, logic [31:0] off, logic h);
        obs_t e;
        bus.branch_taken = bt;
        bus.offset       = off;
        bus.halt         = h;
        if (m_phase == SAMPLE_PHASE) begin
            m_tq  = bt;
            m_tgt = m_pc + off;
        end
        m_fs = 1'b0;
        if (m_phase == UPDATE_PHASE && !h && !m_mis) begin
            if (m_tq && (m_tgt % INSTR_BYTES) != 0) begin
                m_mis = 1'b1;
            end else if (m_tq) begin
                m_pc  = m_tgt;
                m_cnt = m_cnt + 8'd1;
                m_fs  = 1'b1;
            end else begin
                m_pc = m_pc + INSTR_BYTES;
                m_fs = 1'b1;
            end
        end
        m_phase = (m_phase + 1) % PHASE_COUNT;
        e = '{pc: m_pc, phase: 4'(m_phase), fs: m_fs,
              cnt: m_cnt, mis: m_mis};
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // One instruction; off-phase inputs are noise that must not matter.
    task automatic run_instr(logic bt7, logic [31:0] off7, logic h9,
                             logic obt, logic hrand);
        logic        b;
        logic [31:0] o;
        logic        h;
        for (int i = 0; i < PHASE_COUNT; i++) begin
            b = (m_phase == SAMPLE_PHASE) ? bt7 : obt;
            o = (m_phase == SAMPLE_PHASE) ? off7 : $urandom;
            if (m_phase == UPDATE_PHASE)
                h = h9;
            else
                h = hrand ? 1'($urandom_range(0, 1)) : 1'b0;
            step(b, o, h);
        end
    endtask

    task automatic goto(logic [31:0] target);
        run_instr(1'b1, target - m_pc, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserted between edges so the clear must be asynchronous.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        check("rst_strobe", 32'(bus.fetch_strobe), 32'h0);
        check("rst_count", 32'(bus.taken_count), 32'h0);
        check("rst_misaligned", 32'(bus.misaligned), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] off;
        bus.branch_taken = 1'b0;
        bus.offset       = '0;
        bus.halt         = 1'b0;
        m_reset();
        @(negedge clock);
        do_reset();

        for (int i = 0; i < 3; i++)
            run_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("seq_pc", bus.pc, 32'hC);
        check("seq_strobe", 32'(bus.fetch_strobe), 32'h1);
        check("seq_count", 32'(bus.taken_count), 32'h0);

        run_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_instr(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
        check("taken_pc", bus.pc, 32'h8);
        check("taken_count", 32'(bus.taken_count), 32'h1);
        check("taken_strobe", 32'(bus.fetch_strobe), 32'h1);

        run_instr(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
        check("toggle_pc", bus.pc, 32'hC);
        check("toggle_count", 32'(bus.taken_count), 32'h1);

        goto(32'h20);
        run_instr(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("halt_pc", bus.pc, 32'h20);
        check("halt_strobe", 32'(bus.fetch_strobe), 32'h0);
        run_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("unhalt_pc", bus.pc, 32'h24);

        goto(32'h40);
        run_instr(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        check("mis_pc", bus.pc, 32'h40);
        check("mis_flag", 32'(bus.misaligned), 32'h1);
        for (int i = 0; i < 3; i++) begin
            run_instr(1'($urandom_range(0, 1)), 32'h8, 1'b0,
                      1'b1, 1'b1);
            check("mis_frozen_pc", bus.pc, 32'h40);
            check("mis_sticky", 32'(bus.misaligned), 32'h1);
        end
        do_reset();

        goto(32'hFFFF_FFFC);
        run_instr(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wrap_pc", bus.pc, 32'h0);
        check("wrap_strobe", 32'(bus.fetch_strobe), 32'h1);
        for (int i = 0; i < 4; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'b0);
        check("mid_phase", 32'(bus.phase), 32'h4);
        do_reset();

        for (int i = 0; i < 255; i++)
            run_instr(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cnt_max", 32'(bus.taken_count), 32'hFF);
        run_instr(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cnt_wrap", 32'(bus.taken_count), 32'h0);

        for (int i = 0; i < 40; i++) begin
            if (i % 13 == 12)
                do_reset();
            off = $urandom;
            if ($urandom_range(0, 7) != 0)
                off = off & 32'hFFFF_FFFC;
            run_instr(1'($urandom_range(0, 1)), off,
                      ($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        @(posedge clock);
        #2;
        check("sb_drain", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_update.md
Name: pc_update

Overview:
- Consumer end of the branch-decision path: samples the registered branch-taken signal (branch & ALU zero) and commits the next program counter once per instruction.
- Runs its own 10-phase instruction counter, reset together with the branch-decision register so both counters stay in lockstep.
- Sits between the branch-decision register and instruction memory. Drives the fetch address and a one-cycle fetch strobe.

Parameters:
- DATA_W, 32, width of PC, offset and target.
- RESET_PC, 0, PC value loaded on reset.
- PHASE_COUNT, 10, phases per instruction; counter wraps PHASE_COUNT-1 -> 0.
- SAMPLE_PHASE, 7, phase at whose rising edge branch_taken/offset are captured; must be > 5 and < UPDATE_PHASE.
- UPDATE_PHASE, 9, phase at whose rising edge PC is committed.
- INSTR_BYTES, 4, sequential increment.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- branch_taken, input, 1, registered branch decision (branch & alu_0), stable from phase 6 to phase 4 of the next instruction.
- offset, input, DATA_W, sign-extended byte offset of the branch target relative to the current PC.
- halt, input, 1, level; when high at UPDATE_PHASE, PC is not advanced.
- pc, output, DATA_W, current fetch address.
- phase, output, 4, current phase counter value.
- fetch_strobe, output, 1, high for exactly the one cycle in which phase == 0 following a commit.
- taken_count, output, 8, number of committed taken branches, wraps 255 -> 0.
- misaligned, output, 1, sticky error: a taken target was not INSTR_BYTES-aligned.

Behaviour:
- Reset (async, any cycle, including mid-instruction) clears state immediately: pc=RESET_PC, phase=0, fetch_strobe=0, taken_count=0, misaligned=0, taken_q=0, target_q=0.
- Phase counter:
  - increments every clock, modulo PHASE_COUNT;
  - never stalls, including under halt or misaligned.
- Sample edge (phase == SAMPLE_PHASE):
  - taken_q <= branch_taken;
  - target_q <= pc + offset, modulo 2^DATA_W (no overflow flag; wrap-around is legal).
- Commit edge (phase == UPDATE_PHASE), priority order:
  1. halt=1 -> pc held, taken_count held, fetch_strobe not raised next cycle.
  2. misaligned=1 (already set) -> pc held; the block stays frozen until reset.
  3. taken_q=1 and target_q[log2(INSTR_BYTES)-1:0] != 0 -> pc held, misaligned <= 1.
  4. taken_q=1 -> pc <= target_q, taken_count <= taken_count + 1.
  5. otherwise -> pc <= pc + INSTR_BYTES, modulo 2^DATA_W (0xFFFFFFFC -> 0x00000000).
- fetch_strobe:
  - registered; high during phase 0 only if the preceding commit edge took branch 4 or 5;
  - low in all other cycles;
  - low during the first phase 0 after reset (no commit has occurred).
- Timing:
  - Latency from branch_taken valid to PC change is fixed: captured at the phase-7 edge, visible on pc after the phase-9 edge.
  - One instruction = PHASE_COUNT cycles.
- branch_taken/offset changes at any phase other than SAMPLE_PHASE have no effect.
- halt asserted at any phase other than UPDATE_PHASE has no effect.
- pc is constant between commit edges. All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package: PHASE_COUNT, SAMPLE_PHASE, UPDATE_PHASE, INSTR_BYTES, and the phase width constant (4). The branch-decision register uses the same constants, so its phase 5 is derived from this package.
- One natural sub-module: phase_counter (mod-PHASE_COUNT counter with async reset, outputs phase and one-hot strobes for sample/update). Instantiated here; reusable by the branch-decision register.
- Next-PC mux and alignment check stay inline.

Test Plan:
- Sequential: reset, branch_taken=0 for 3 instructions -> pc 0x0 -> 0x4 -> 0x8 -> 0xC, each change one cycle after a phase-9 edge; fetch_strobe pulses at each following phase 0; taken_count=0.
- Taken branch: pc=0x10, branch_taken=1, offset=0xFFFFFFF8 at phase 7 -> pc=0x08 after phase 9, taken_count=1, fetch_strobe=1 in next phase 0.
- Late/early toggling: branch_taken=1 only during phases 0-6 and 8-9, 0 at phase 7 -> pc advances by 4; taken_count unchanged.
- Halt: halt=1 across the phase-9 edge with pc=0x20 -> pc stays 0x20, no fetch_strobe, phase keeps counting; halt=0 next instruction -> pc=0x24.
- Misaligned: taken with offset=0x2 at pc=0x40 -> pc stays 0x40, misaligned=1 and remains 1 with pc frozen across 3 further instructions until reset.
- Reset mid-instruction and wrap: pc=0xFFFFFFFC not-taken -> pc=0x0; then assert reset at phase 4 -> pc=RESET_PC, phase=0, taken_count=0, misaligned=0 in the same cycle, without waiting for a clock edge.
